triangule_area: RTL and testbench

TRIANGULE_AREA -- requirements
Module: triangule_area

---
 rtl/triangule_area_pkg.sv | 15 +
 rtl/triangule_area.sv | 131 +++++++++++++
 tb/tb_triangule_area.sv | 130 +++++++++++++
 3 files changed

// File: rtl/triangule_area_pkg.sv
// rtl/triangule_area_pkg.sv - shared widths and FSM state encoding for triangule_area
package triangule_area_pkg;

   localparam int COORD_W = 11;
   localparam int AREA_W  = 24;

   typedef enum logic [2:0] {
      LOAD = 3'd0,
      DIFF = 3'd1,
      MUL  = 3'd2,
      SUM  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/triangule_area.sv
// rtl/triangule_area.sv - doubled triangle area |x1(y2-y3)+x2(y3-y1)+x3(y1-y2)| over a fixed 5-state schedule
module triangule_area #(
   parameter int COORD_W = triangule_area_pkg::COORD_W,
   parameter int AREA_W  = triangule_area_pkg::AREA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [COORD_W-1:0] a1x,
   input  logic signed [COORD_W-1:0] a1y,
   input  logic signed [COORD_W-1:0] a2x,
   input  logic signed [COORD_W-1:0] a2y,
   input  logic signed [COORD_W-1:0] a3x,
   input  logic signed [COORD_W-1:0] a3y,
   output logic signed [AREA_W-1:0]  area,
   output logic                      write
);
   import triangule_area_pkg::*;

   localparam int DW = COORD_W + 1;
   localparam int PW = 2 * COORD_W + 1;
   localparam int SW = AREA_W + 1;

   state_t state_q, state_d;

   logic signed [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
   logic signed [COORD_W-1:0] x1_d, y1_d, x2_d, y2_d, x3_d, y3_d;
   logic signed [DW-1:0]      d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
   logic signed [PW-1:0]      p0_q, p1_q, p2_q, p0_d, p1_d, p2_d;
   logic signed [AREA_W-1:0]  area_q, area_d;
   logic signed [SW-1:0]      sum_v, abs_v;

   always_comb begin
      state_d = LOAD;
      case (state_q)
         LOAD:    state_d = DIFF;
         DIFF:    state_d = MUL;
         MUL:     state_d = SUM;
         SUM:     state_d = DONE;
         DONE:    state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Each stage register only loads on the edge leaving its own state, so
   // input changes outside LOAD never reach the result in flight.
   always_comb begin
      x1_d = x1_q;
      y1_d = y1_q;
      x2_d = x2_q;
      y2_d = y2_q;
      x3_d = x3_q;
      y3_d = y3_q;
      if (state_q == LOAD) begin
         x1_d = a1x;
         y1_d = a1y;
         x2_d = a2x;
         y2_d = a2y;
         x3_d = a3x;
         y3_d = a3y;
      end
   end

   always_comb begin
      d0_d = d0_q;
      d1_d = d1_q;
      d2_d = d2_q;
      if (state_q == DIFF) begin
         d0_d = DW'(y2_q) - DW'(y3_q);
         d1_d = DW'(y3_q) - DW'(y1_q);
         d2_d = DW'(y1_q) - DW'(y2_q);
      end
   end

   always_comb begin
      p0_d = p0_q;
      p1_d = p1_q;
      p2_d = p2_q;
      if (state_q == MUL) begin
         p0_d = PW'(x1_q) * PW'(d0_q);
         p1_d = PW'(x2_q) * PW'(d1_q);
         p2_d = PW'(x3_q) * PW'(d2_q);
      end
   end

   always_comb begin
      sum_v  = SW'(p0_q) + SW'(p1_q) + SW'(p2_q);
      abs_v  = sum_v[SW-1] ? -sum_v : sum_v;
      area_d = area_q;
      if (state_q == SUM) begin
         area_d = AREA_W'(abs_v);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         x1_q    <= '0;
         y1_q    <= '0;
         x2_q    <= '0;
         y2_q    <= '0;
         x3_q    <= '0;
         y3_q    <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         area_q  <= '0;
      end else begin
         state_q <= state_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         x2_q    <= x2_d;
         y2_q    <= y2_d;
         x3_q    <= x3_d;
         y3_q    <= y3_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         area_q  <= area_d;
      end
   end

   assign area  = area_q;
   assign write = (state_q == DONE);

endmodule

// File: tb/tb_triangule_area.sv
// tb/tb_triangule_area.sv - directed self-checking bench for triangule_area
module tb_triangule_area;

   localparam int COORD_W = 11;
   localparam int AREA_W  = 24;

   logic                      clk;
   logic                      rst;
   logic signed [COORD_W-1:0] a1x, a1y, a2x, a2y, a3x, a3y;
   logic signed [AREA_W-1:0]  area;
   logic                      write;

   int vectors;
   int miscompares;
   int cyc;

   triangule_area #(.COORD_W(COORD_W), .AREA_W(AREA_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .a1x   (a1x),
      .a1y   (a1y),
      .a2x   (a2x),
      .a2y   (a2y),
      .a3x   (a3x),
      .a3y   (a3y),
      .area  (area),
      .write (write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_tri(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3);
      a1x = COORD_W'(x1);
      a1y = COORD_W'(y1);
      a2x = COORD_W'(x2);
      a2y = COORD_W'(y2);
      a3x = COORD_W'(x3);
      a3y = COORD_W'(y3);
   endtask

   // Counts falling edges until write is seen high, bounded so a dead FSM still ends.
   task automatic wait_write(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (write !== 1'b1 && n < 20);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      set_tri(0, 0, 4, 0, 0, 3);

      #3;
      check("reset_area", 32'(area), 0);
      check("reset_write", 32'(write), 0);
      @(negedge clk);
      @(negedge clk);
      check("reset_hold_write", 32'(write), 0);

      rst = 1'b0;
      wait_write(cyc);
      check("first_write_latency", cyc, 4);
      check("ccw_area", 32'(area), 12);

      set_tri(0, 0, 0, 3, 4, 0);
      wait_write(cyc);
      check("period_cw", cyc, 5);
      check("cw_area", 32'(area), 12);

      @(negedge clk);
      check("hold_write_low", 32'(write), 0);
      check("hold_area", 32'(area), 12);

      set_tri(1, 1, 2, 2, 3, 3);
      wait_write(cyc);
      check("period_collinear", cyc, 4);
      check("collinear_area", 32'(area), 0);

      set_tri(-1024, -1024, 1023, -1024, -1024, 1023);
      wait_write(cyc);
      check("period_extreme", cyc, 5);
      check("extreme_area", 32'(area), 4190209);

      set_tri(0, 0, 6, 0, 0, 5);
      @(negedge clk);
      @(negedge clk);
      check("area_held_in_diff", 32'(area), 4190209);
      set_tri(7, -3, 100, 9, -50, 2);
      @(negedge clk);
      set_tri(-1000, 1000, 1000, -1000, 5, 5);
      @(negedge clk);
      set_tri(1, 2, 3, 4, 5, 6);
      @(negedge clk);
      check("disturb_write", 32'(write), 1);
      check("disturb_area", 32'(area), 30);

      set_tri(0, 0, 4, 0, 0, 3);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_area", 32'(area), 30);
      rst = 1'b1;
      #1;
      check("midreset_area", 32'(area), 0);
      check("midreset_write", 32'(write), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_write(cyc);
      check("rerun_latency", cyc, 4);
      check("rerun_area", 32'(area), 12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
